// File: rtl/soc_addr_router.sv
// Single-master request router: decodes the SoC address map, forwards one request at a time
// to the selected target and returns its response, or an internal error on miss/timeout.
//   state | meaning
//   IDLE  | ready for a master request
//   ISSUE | request valid driven to the selected target
//   WAIT  | target accepted, waiting for its response
//   RESP  | response held to the master until accepted
module soc_addr_router #(
    parameter int unsigned NrTargets     = 9,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [63:0]             req_addr_i,
    input  logic                    req_we_i,
    input  logic [63:0]             req_wdata_i,
    input  logic [7:0]              req_be_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [63:0]             rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [NrTargets-1:0]    slv_req_valid_o,
    input  logic [NrTargets-1:0]    slv_req_ready_i,
    output logic [63:0]             slv_addr_o,
    output logic                    slv_we_o,
    output logic [63:0]             slv_wdata_o,
    output logic [7:0]              slv_be_o,
    input  logic [NrTargets-1:0]    slv_rsp_valid_i,
    input  logic [NrTargets*64-1:0] slv_rsp_rdata_i,
    input  logic [NrTargets-1:0]    slv_rsp_err_i
);

    localparam int unsigned IdxW = $clog2(NrTargets);
    localparam int unsigned CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    // Map order: DRAM, GPIO, Ethernet, SPI, UART, PLIC, CLINT, ROM, Debug; end is exclusive.
    localparam logic [63:0] MapBase [9] = '{
        64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000, 64'h1000_0000,
        64'h0C00_0000, 64'h0200_0000, 64'h0001_0000, 64'h0000_0000};
    localparam logic [63:0] MapEnd [9] = '{
        64'hC000_0000, 64'h4000_1000, 64'h3001_0000, 64'h2080_0000, 64'h1000_1000,
        64'h0FFF_FFFF, 64'h020C_0000, 64'h0002_0000, 64'h0000_1000};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              ready_q;
    logic [IdxW-1:0]   idx_q;
    logic [CntW-1:0]   cnt_q;
    logic [63:0]       addr_q, wdata_q, rdata_q;
    logic [7:0]        be_q;
    logic              we_q, err_q;

    logic              dec_hit;
    logic [IdxW-1:0]   dec_idx;
    logic              sel_ready, sel_rsp, sel_err;
    logic [63:0]       sel_rdata;
    logic              accept, busy, rsp_take, timeout_hit;

    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = 0; i < 9; i++) begin
            if (req_addr_i >= MapBase[i] && req_addr_i < MapEnd[i]) begin
                dec_hit = 1'b1;
                dec_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rsp   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NrTargets; i++) begin
            if (idx_q == IdxW'(i)) begin
                sel_ready = slv_req_ready_i[i];
                sel_rsp   = slv_rsp_valid_i[i];
                sel_err   = slv_rsp_err_i[i];
                sel_rdata = slv_rsp_rdata_i[i*64 +: 64];
            end
        end
    end

    assign accept = ready_q && req_valid_i;
    assign busy   = (state_q == ISSUE) || (state_q == WAIT);
    // A response in ISSUE only counts when it coincides with the target's accept.
    assign rsp_take = ((state_q == ISSUE) && sel_ready && sel_rsp) ||
                      ((state_q == WAIT) && sel_rsp);
    assign timeout_hit = busy && (cnt_q == CntLast) && !rsp_take;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = dec_hit ? ISSUE : RESP;
            ISSUE: begin
                if (rsp_take || timeout_hit) state_d = RESP;
                else if (sel_ready)          state_d = WAIT;
            end
            WAIT:    if (rsp_take || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = ready_q;
        rsp_valid_o = (state_q == RESP);
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
        for (int i = 0; i < NrTargets; i++) begin
            slv_req_valid_o[i] = (state_q == ISSUE) && (idx_q == IdxW'(i));
        end
    end

    assign slv_addr_o  = addr_q;
    assign slv_we_o    = we_q;
    assign slv_wdata_o = wdata_q;
    assign slv_be_o    = be_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            idx_q   <= dec_idx;
            cnt_q   <= '0;
            addr_q  <= req_addr_i;
            we_q    <= req_we_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
            rdata_q <= '0;
            err_q   <= !dec_hit;
        end else begin
            if (busy) cnt_q <= cnt_q + CntW'(1);
            if (rsp_take) begin
                rdata_q <= sel_rdata;
                err_q   <= sel_err;
            end else if (timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_soc_addr_router.sv
// Scoreboard bench for soc_addr_router: stimulus pushes expected responses from an
// address-map reference model, a monitor pops and compares whenever a response appears.
module tb_soc_addr_router;

    localparam int NT = 9;
    localparam int TO = 1024;

    localparam logic [63:0] BASE [NT] = '{
        64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000, 64'h1000_0000,
        64'h0C00_0000, 64'h0200_0000, 64'h0001_0000, 64'h0000_0000};
    localparam logic [63:0] LEN [NT] = '{
        64'h4000_0000, 64'h0000_1000, 64'h0001_0000, 64'h0080_0000, 64'h0000_1000,
        64'h03FF_FFFF, 64'h000C_0000, 64'h0001_0000, 64'h0000_1000};

    logic             clk = 1'b0;
    logic             rst_i;
    logic             req_valid_i, req_ready_o;
    logic [63:0]      req_addr_i;
    logic             req_we_i;
    logic [63:0]      req_wdata_i;
    logic [7:0]       req_be_i;
    logic             rsp_valid_o, rsp_ready_i;
    logic [63:0]      rsp_rdata_o;
    logic             rsp_err_o;
    logic [NT-1:0]    slv_req_valid_o, slv_req_ready_i;
    logic [63:0]      slv_addr_o;
    logic             slv_we_o;
    logic [63:0]      slv_wdata_o;
    logic [7:0]       slv_be_o;
    logic [NT-1:0]    slv_rsp_valid_i;
    logic [NT*64-1:0] slv_rsp_rdata_i;
    logic [NT-1:0]    slv_rsp_err_i;

    soc_addr_router #(.NrTargets(NT), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .slv_req_valid_o(slv_req_valid_o), .slv_req_ready_i(slv_req_ready_i),
        .slv_addr_o(slv_addr_o), .slv_we_o(slv_we_o), .slv_wdata_o(slv_wdata_o),
        .slv_be_o(slv_be_o), .slv_rsp_valid_i(slv_rsp_valid_i),
        .slv_rsp_rdata_i(slv_rsp_rdata_i), .slv_rsp_err_i(slv_rsp_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          rise;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          n_cmp = 0, n_fail = 0;
    int          cyc = 0, acc_cyc = 0;
    bit          in_resp = 0, rdy_chk = 0;
    bit          tgt_active = 0;
    int          plan_idx = 0, plan_rdy = 0, plan_rsp = -1, plan_spur_tgt = -1, plan_spur_at = 0;
    logic [63:0] plan_rdata = '0;
    logic        plan_err = 1'b0;
    logic [63:0] sent_wdata;
    logic [7:0]  sent_be;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got no event expected one within bound (cycle %0d)", name, cyc);
    endtask

    // Reference decode: offset from base below the region length, unsigned.
    function automatic void ref_decode(input logic [63:0] a, output bit hit, output int idx);
        hit = 0;
        idx = 0;
        for (int i = 0; i < NT; i++) begin
            if ((a - BASE[i]) < LEN[i]) begin
                hit = 1;
                idx = i;
            end
        end
    endfunction

    // Target model: the planned target accepts/answers at cycles relative to the accept,
    // every other target produces random ready/valid noise.
    always begin : target_model
        int n;
        @(posedge clk);
        #1;
        for (int i = 0; i < NT; i++) slv_rsp_rdata_i[i*64 +: 64] = {$urandom, $urandom};
        slv_rsp_err_i   = NT'($urandom);
        slv_req_ready_i = NT'($urandom);
        slv_rsp_valid_i = ($urandom_range(0, 3) == 0) ? NT'($urandom) : '0;
        if (tgt_active) begin
            n = cyc - acc_cyc;
            slv_req_ready_i[plan_idx] = (n >= plan_rdy) && slv_req_valid_o[plan_idx];
            slv_rsp_valid_i[plan_idx] = 1'b0;
            if (n == plan_rsp) begin
                slv_rsp_valid_i[plan_idx]             = 1'b1;
                slv_rsp_rdata_i[plan_idx*64 +: 64]    = plan_rdata;
                slv_rsp_err_i[plan_idx]               = plan_err;
            end
            if (plan_spur_tgt >= 0 && n == plan_spur_at) slv_rsp_valid_i[plan_spur_tgt] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_i) begin
            in_resp = 0;
            rdy_chk = 0;
        end else begin
            if (rdy_chk) begin
                chk("req_ready_after_rsp", 64'(req_ready_o), 64'd1);
                rdy_chk = 0;
            end
            if (rsp_valid_o) begin
                if (!in_resp) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_rsp_absent");
                        cur.rdata = rsp_rdata_o;
                        cur.err   = rsp_err_o;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rsp_cycle", 64'(cyc), 64'(cur.rise));
                        chk("rsp_rdata", rsp_rdata_o, cur.rdata);
                        chk("rsp_err", 64'(rsp_err_o), 64'(cur.err));
                    end
                    in_resp = 1;
                end else begin
                    chk("rsp_rdata_held", rsp_rdata_o, cur.rdata);
                    chk("rsp_err_held", 64'(rsp_err_o), 64'(cur.err));
                end
                chk("req_ready_in_resp", 64'(req_ready_o), 64'd0);
                if (rsp_ready_i) begin
                    in_resp = 0;
                    rdy_chk = 1;
                end
            end
        end
    end

    // Called just after a rising edge; returns at the negedge of the accept cycle.
    task automatic issue(input logic [63:0] addr, input bit we, input int rdy, input int rsp,
                         input logic [63:0] rdata, input logic err,
                         input int spur_tgt, input int spur_at,
                         output bit hit, output int idx, output bit ok);
        ref_decode(addr, hit, idx);
        sent_wdata  = {$urandom, $urandom};
        sent_be     = 8'($urandom);
        req_addr_i  = addr;
        req_we_i    = we;
        req_wdata_i = sent_wdata;
        req_be_i    = sent_be;
        req_valid_i = 1'b1;
        ok = 0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            if (req_ready_o) ok = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) fail_now("req_accept");
        acc_cyc       = cyc;
        plan_idx      = idx;
        plan_rdy      = rdy;
        plan_rsp      = rsp;
        plan_rdata    = rdata;
        plan_err      = err;
        plan_spur_tgt = spur_tgt;
        plan_spur_at  = spur_at;
        tgt_active    = ok && hit;
    endtask

    // Starts at a negedge; returns just after the edge following the response handshake.
    task automatic finish_txn(input int hold);
        int  held = 0;
        int  w = 0;
        bit  done = 0;
        while (!done && w < TO + 40) begin
            if (rsp_valid_o && rsp_ready_i) done = 1;
            else begin
                if (rsp_valid_o) held++;
                @(posedge clk);
                #1;
                if (held >= hold) rsp_ready_i = 1'b1;
                @(negedge clk);
                w++;
            end
        end
        if (!done) begin
            fail_now("rsp_handshake");
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        tgt_active  = 0;
    endtask

    task automatic run_txn(input logic [63:0] addr, input bit we, input int rdy, input int rsp,
                           input int hold, input logic [63:0] rdata, input logic err,
                           input int spur_tgt, input int spur_at, input int bp);
        bit         hit, ok, answered;
        int         idx;
        exp_t       e;
        logic [8:0] oh;
        issue(addr, we, rdy, rsp, rdata, err, spur_tgt, spur_at, hit, idx, ok);
        if (!ok) begin
            req_valid_i = 1'b0;
            return;
        end
        answered = hit && rsp >= 1 && rsp <= TO;
        e.rise  = acc_cyc + (!hit ? 1 : (answered ? rsp + 1 : TO + 1));
        e.rdata = answered ? rdata : 64'd0;
        e.err   = answered ? err : 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_addr_i  = {$urandom, $urandom};
        req_we_i    = 1'($urandom);
        req_wdata_i = {$urandom, $urandom};
        req_be_i    = 8'($urandom);
        rsp_ready_i = (hold == 0);
        @(negedge clk);
        oh = hit ? (9'd1 << idx) : 9'd0;
        chk("slv_valid_c1", 64'(slv_req_valid_o), 64'(oh));
        if (hit) begin
            chk("slv_addr", slv_addr_o, addr);
            chk("slv_we", 64'(slv_we_o), 64'(we));
            chk("slv_wdata", slv_wdata_o, sent_wdata);
            chk("slv_be", 64'(slv_be_o), 64'(sent_be));
        end
        for (int c = 2; c <= bp; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("slv_valid_held", 64'(slv_req_valid_o), 64'(oh));
            chk("slv_addr_held", slv_addr_o, addr);
            chk("slv_wdata_held", slv_wdata_o, sent_wdata);
        end
        finish_txn(hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata_o, 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
        chk({tag, "_slv_valid"}, 64'(slv_req_valid_o), 64'd0);
        chk({tag, "_slv_addr"}, slv_addr_o, 64'd0);
        chk({tag, "_slv_wdata"}, slv_wdata_o, 64'd0);
        chk({tag, "_slv_we_be"}, {55'd0, slv_we_o, slv_be_o}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of run expected one by time limit");
        $fatal(1);
    end

    initial begin
        bit          hit, ok;
        int          idx, tg, mode, rdy, rsp, spur_tgt, spur_at;
        logic [63:0] a;

        rst_i = 1'b1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        req_addr_i = '0;
        req_we_i = 1'b0;
        req_wdata_i = '0;
        req_be_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("req_ready_post_reset", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1;

        run_txn(64'h1000_0008, 0, 1, 3, 0, 64'h41, 1'b0, -1, 0, 0);
        run_txn(64'h0FFF_FFFE, 1, 2, 2, 0, {$urandom, $urandom}, 1'b0, -1, 0, 0);
        run_txn(64'h0FFF_FFFF, 0, 1, 1, 0, 64'h0, 1'b0, -1, 0, 0);
        run_txn(64'h0002_0000, 0, 1, 1, 0, 64'h0, 1'b0, -1, 0, 0);
        run_txn(64'hC000_0000, 1, 1, 1, 1, 64'h0, 1'b0, -1, 0, 0);
        // Silent DRAM target: its response arrives one cycle too late.
        run_txn(64'h8000_0000, 1, 1, TO + 1, 0, 64'hDEAD_BEEF, 1'b0, -1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        run_txn(64'h4000_0010, 0, 1, 2, 0, 64'h1234_5678_9ABC_DEF0, 1'b0, -1, 0, 0);
        // Response on the last allowed cycle wins over the timeout.
        run_txn(64'h2000_0040, 0, 1, TO, 0, 64'hCAFE_F00D, 1'b1, -1, 0, 0);
        run_txn(64'h3000_0000, 1, 6, 7, 3, {$urandom, $urandom}, 1'b0, -1, 0, 5);
        run_txn(64'h0001_0000, 0, 1, 1, 0, 64'h0BAD_C0DE, 1'b0, -1, 0, 0);
        run_txn(64'h1000_0FF8, 0, 1, 5, 0, 64'h55AA, 1'b0, 1, 3, 0);

        issue(64'h2000_0100, 0, 1, -1, 64'h0, 1'b0, -1, 0, hit, idx, ok);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wait_slv_valid_low", 64'(slv_req_valid_o), 64'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        tgt_active = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("req_ready_after_midreset", 64'(req_ready_o), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        run_txn(64'h0200_BFF8, 0, 2, 3, 1, {$urandom, $urandom}, 1'b0, -1, 0, 0);

        for (int t = 0; t < 40; t++) begin
            tg   = $urandom_range(0, NT - 1);
            mode = $urandom_range(0, 3);
            case (mode)
                0:       a = BASE[tg] + ({$urandom, $urandom} % LEN[tg]);
                1:       a = BASE[tg] + LEN[tg] - 64'd1;
                2:       a = BASE[tg] + LEN[tg];
                default: a = {$urandom, $urandom};
            endcase
            ref_decode(a, hit, idx);
            rdy = $urandom_range(1, 4);
            rsp = rdy + $urandom_range(0, 4);
            spur_tgt = ($urandom_range(0, 2) == 0) ? (idx + 1 + $urandom_range(0, NT - 2)) % NT : -1;
            spur_at  = $urandom_range(1, rsp);
            run_txn(a, 1'($urandom), rdy, rsp, $urandom_range(0, 2), {$urandom, $urandom},
                    1'($urandom_range(0, 3) == 0), spur_tgt, spur_at, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
